// File: rtl/draw_tilemap.sv
// Background tile-map renderer: walks the screen one 8x8 tile at a time, fetches each
// tile index from a synchronous map RAM and hands it to the downstream tile drawer.
// The map wraps horizontally; the scroll column is captured once per frame at Start.
module draw_tilemap #(
  parameter int unsigned COLS       = 20,
  parameter int unsigned ROWS       = 15,
  parameter int unsigned MAP_W_LOG2 = 6
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [MAP_W_LOG2-1:0] ScrollCol,
  output logic [MAP_W_LOG2+3:0] MapAddr,
  input  logic [3:0]            MapData,
  output logic [7:0]            TileX,
  output logic [6:0]            TileY,
  output logic [3:0]            TileSel,
  output logic                  TileEnable,
  input  logic                  TileDone,
  output logic                  Busy,
  output logic                  FrameDone
);

  localparam logic [4:0] LastCol = 5'(COLS - 1);
  localparam logic [3:0] LastRow = 4'(ROWS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StIssue,
    StWaitAck,
    StWaitDone,
    StNext,
    StFinish
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            col_q, col_d;
  logic [3:0]            row_q, row_d;
  logic [MAP_W_LOG2-1:0] scroll_q, scroll_d;
  logic [7:0]            tile_x_q, tile_x_d;
  logic [6:0]            tile_y_q, tile_y_d;
  logic [3:0]            tile_sel_q, tile_sel_d;
  logic [MAP_W_LOG2-1:0] map_col;

  // State and datapath registers, synchronous active-low reset aborts any frame.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      scroll_q   <= '0;
      tile_x_q   <= '0;
      tile_y_q   <= '0;
      tile_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      scroll_q   <= scroll_d;
      tile_x_q   <= tile_x_d;
      tile_y_q   <= tile_y_d;
      tile_sel_q <= tile_sel_d;
    end
  end

  // Next-state logic: fetch, latch, issue, then handshake with the drawer per tile.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    scroll_d   = scroll_q;
    tile_x_d   = tile_x_q;
    tile_y_d   = tile_y_q;
    tile_sel_d = tile_sel_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          scroll_d = ScrollCol;
          col_d    = '0;
          row_d    = '0;
          state_d  = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        // Drawer offsets from these combinationally, so they only change here.
        tile_sel_d = MapData;
        tile_x_d   = {col_q, 3'b000};
        tile_y_d   = {row_q, 3'b000};
        state_d    = StIssue;
      end
      StIssue: state_d = StWaitAck;
      StWaitAck: begin
        if (!TileDone) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (TileDone) state_d = StNext;
      end
      StNext: begin
        if (col_q == LastCol) begin
          if (row_q == LastRow) begin
            state_d = StFinish;
          end else begin
            col_d   = '0;
            row_d   = row_q + 4'd1;
            state_d = StFetch;
          end
        end else begin
          col_d   = col_q + 5'd1;
          state_d = StFetch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Map column wraps by truncation to the map width.
  always_comb begin
    map_col = MAP_W_LOG2'(col_q) + scroll_q;
    MapAddr = {row_q, map_col};
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    TileEnable = (state_q == StIssue);
    Busy       = (state_q != StIdle);
    FrameDone  = (state_q == StFinish);
    TileX      = tile_x_q;
    TileY      = tile_y_q;
    TileSel    = tile_sel_q;
  end

endmodule

// File: tb/tb_draw_tilemap.sv
// Bench for draw_tilemap: synchronous map RAM model, behavioural tile drawer, and a
// scoreboard of expected per-tile draw requests checked by an independent monitor.
module tb_draw_tilemap;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start;
  logic [5:0] ScrollCol;
  logic [9:0] MapAddr;
  logic [3:0] MapData;
  logic [7:0] TileX;
  logic [6:0] TileY;
  logic [3:0] TileSel;
  logic       TileEnable;
  logic       TileDone;
  logic       Busy;
  logic       FrameDone;

  always #5 Clock = ~Clock;

  draw_tilemap dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Start      (Start),
    .ScrollCol  (ScrollCol),
    .MapAddr    (MapAddr),
    .MapData    (MapData),
    .TileX      (TileX),
    .TileY      (TileY),
    .TileSel    (TileSel),
    .TileEnable (TileEnable),
    .TileDone   (TileDone),
    .Busy       (Busy),
    .FrameDone  (FrameDone)
  );

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] x;
    logic [6:0] y;
    logic [3:0] sel;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Map RAM: map[a] = a % 16, one-cycle read latency.
  logic [3:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 4'(i % 16);
  always @(posedge Clock) MapData <= mem[MapAddr];

  // Drawer model: TileDone drops after TileEnable and stays low for a programmable time.
  int drawer_len = 2;
  int stall_tile = -1;
  int busy_cnt   = 0;
  int dtiles     = 0;
  always @(posedge Clock) begin
    if (!Resetn) begin
      TileDone <= 1'b1;
      busy_cnt <= 0;
      dtiles   <= 0;
    end else if (TileEnable) begin
      TileDone <= 1'b0;
      busy_cnt <= (dtiles == stall_tile) ? 500 : drawer_len;
      dtiles   <= dtiles + 1;
    end else begin
      if (!Busy) dtiles <= 0;
      if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
      else if (busy_cnt == 1) begin
        busy_cnt <= 0;
        TileDone <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected tile per TileEnable, captures per-frame tile data.
  int         frames    = 0;
  int         enables   = 0;
  int         tile_idx  = 0;
  exp_t       e;
  logic [9:0] cap_addr [300];
  logic [7:0] cap_x    [300];
  logic [6:0] cap_y    [300];
  logic [3:0] cap_sel  [300];
  always @(negedge Clock) begin
    if (Busy === 1'b0) tile_idx = 0;
    if (TileEnable === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_enable: got addr %0d expected no request", MapAddr);
      end else begin
        e = sb.pop_front();
        check("sb_addr", 32'(MapAddr), 32'(e.addr));
        check("sb_tilex", 32'(TileX), 32'(e.x));
        check("sb_tiley", 32'(TileY), 32'(e.y));
        check("sb_tilesel", 32'(TileSel), 32'(e.sel));
      end
      if (tile_idx < 300) begin
        cap_addr[tile_idx] = MapAddr;
        cap_x[tile_idx]    = TileX;
        cap_y[tile_idx]    = TileY;
        cap_sel[tile_idx]  = TileSel;
      end
      tile_idx++;
      enables++;
    end
    if (FrameDone === 1'b1) frames++;
  end

  task automatic push_frame(input int scroll);
    exp_t x;
    int   a;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 20; c++) begin
        a     = r * 64 + ((c + scroll) % 64);
        x.addr = 10'(a);
        x.x    = 8'(c * 8);
        x.y    = 7'(r * 8);
        x.sel  = 4'(a % 16);
        sb.push_back(x);
      end
    end
  endtask

  task automatic start_frame(input logic [5:0] scroll);
    @(negedge Clock);
    ScrollCol = scroll;
    Start     = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check("frame_done_within_budget", 32'(frames >= target), 32'd1);
  endtask

  task automatic wait_tile(input int target, input int budget);
    int n = 0;
    while (tile_idx < target && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check("tile_reached_within_budget", 32'(tile_idx >= target), 32'd1);
  endtask

  int   f0;
  int   en0;
  logic en_seen, x_bad, y_bad, sel_bad, busy_bad;

  initial begin
    Resetn    = 1'b0;
    Start     = 1'b1;
    ScrollCol = 6'd0;

    // 1: reset held with Start high
    repeat (3) begin
      @(negedge Clock);
      check("rst_tile_enable", 32'(TileEnable), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
    end
    check("rst_frame_done", 32'(FrameDone), 32'd0);
    check("rst_tilex", 32'(TileX), 32'd0);
    check("rst_tiley", 32'(TileY), 32'd0);
    check("rst_tilesel", 32'(TileSel), 32'd0);
    check("rst_mapaddr", 32'(MapAddr), 32'd0);
    Start  = 1'b0;
    Resetn = 1'b1;
    @(negedge Clock);
    check("idle_busy", 32'(Busy), 32'd0);

    // 2: full frame, scroll 0, slow drawer
    drawer_len = 130;
    f0  = frames;
    en0 = enables;
    push_frame(0);
    start_frame(6'd0);
    wait_frames(f0 + 1, 45000);
    repeat (10) @(negedge Clock);
    check("f2_enables", 32'(enables - en0), 32'd300);
    check("f2_framedone_count", 32'(frames - f0), 32'd1);
    check("f2_first_x", 32'(cap_x[0]), 32'd0);
    check("f2_first_y", 32'(cap_y[0]), 32'd0);
    check("f2_first_sel", 32'(cap_sel[0]), 32'd0);
    check("f2_last_addr", 32'(cap_addr[299]), 32'd915);
    check("f2_last_x", 32'(cap_x[299]), 32'd152);
    check("f2_last_y", 32'(cap_y[299]), 32'd112);
    check("f2_last_sel", 32'(cap_sel[299]), 32'd3);
    check("f2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: map wrap with scroll 50
    drawer_len = 2;
    f0 = frames;
    push_frame(50);
    start_frame(6'd50);
    wait_frames(f0 + 1, 5000);
    check("wrap_r2c13", 32'(cap_addr[53]), 32'd191);
    check("wrap_r2c14", 32'(cap_addr[54]), 32'd128);
    check("wrap_r2c19", 32'(cap_addr[59]), 32'd133);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // 4: drawer stalls on tile 5
    stall_tile = 5;
    f0 = frames;
    push_frame(0);
    start_frame(6'd0);
    wait_tile(6, 200);
    en_seen  = 1'b0;
    x_bad    = 1'b0;
    y_bad    = 1'b0;
    sel_bad  = 1'b0;
    busy_bad = 1'b0;
    repeat (5) @(negedge Clock);
    repeat (480) begin
      @(negedge Clock);
      en_seen  |= TileEnable;
      x_bad    |= (TileX != 8'd40);
      y_bad    |= (TileY != 7'd0);
      sel_bad  |= (TileSel != 4'd5);
      busy_bad |= (Busy != 1'b1);
    end
    check("stall_no_enable", 32'(en_seen), 32'd0);
    check("stall_tilex_stable", 32'(x_bad), 32'd0);
    check("stall_tiley_stable", 32'(y_bad), 32'd0);
    check("stall_tilesel_stable", 32'(sel_bad), 32'd0);
    check("stall_busy", 32'(busy_bad), 32'd0);
    stall_tile = -1;
    wait_frames(f0 + 1, 5000);
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // 5: Start and ScrollCol changes mid-frame are ignored
    f0 = frames;
    push_frame(0);
    start_frame(6'd0);
    wait_tile(10, 500);
    @(negedge Clock);
    Start     = 1'b1;
    ScrollCol = 6'd10;
    repeat (3) @(negedge Clock);
    Start = 1'b0;
    wait_frames(f0 + 1, 5000);
    repeat (20) @(negedge Clock);
    check("midstart_framedone_count", 32'(frames - f0), 32'd1);
    check("midstart_idle_after", 32'(Busy), 32'd0);
    check("midstart_sb_empty", 32'(sb.size()), 32'd0);

    // 6: reset during tile 100's wait, then restart
    drawer_len = 20;
    push_frame(7);
    start_frame(6'd7);
    wait_tile(101, 5000);
    repeat (5) @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_tile_enable", 32'(TileEnable), 32'd0);
    check("abort_frame_done", 32'(FrameDone), 32'd0);
    check("abort_tilex", 32'(TileX), 32'd0);
    check("abort_tiley", 32'(TileY), 32'd0);
    check("abort_tilesel", 32'(TileSel), 32'd0);
    check("abort_mapaddr", 32'(MapAddr), 32'd0);
    Resetn = 1'b1;
    sb.delete();
    drawer_len = 2;
    f0 = frames;
    push_frame(7);
    start_frame(6'd7);
    wait_frames(f0 + 1, 5000);
    check("restart_addr", 32'(cap_addr[0]), 32'd7);
    check("restart_x", 32'(cap_x[0]), 32'd0);
    check("restart_y", 32'(cap_y[0]), 32'd0);
    check("restart_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
